// File: rtl/r_response_memory.sv
// Response memory: parks R beats in a shared slot pool, linked per uid, and releases them in per-uid FIFO order.
// Optional occupancy / peak statistics outputs are built when RM_STATS_EN is defined.
module r_response_memory #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 2,
  parameter int NUM_SLOTS  = 32,
  parameter int MAX_LEN    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  store_valid,
  output logic                  store_ready,
  input  logic [ID_WIDTH-1:0]   store_id,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [RESP_WIDTH-1:0] store_resp,
  input  logic                  store_last,
  input  logic [ID_WIDTH-1:0]   release_uid,
  input  logic                  release_ready,
  output logic                  release_valid,
  output logic [DATA_WIDTH-1:0] release_data,
  output logic [RESP_WIDTH-1:0] release_resp,
  output logic                  release_last
`ifdef RM_STATS_EN
  ,
  output logic [$clog2(NUM_SLOTS+1)-1:0] occupancy,
  output logic [$clog2(NUM_SLOTS+1)-1:0] peak_occupancy
`endif
);

  localparam int NUM_UIDS = 2**ID_WIDTH;
  localparam int SW       = $clog2(NUM_SLOTS);
  localparam int CW       = $clog2(MAX_LEN+1);

  logic [DATA_WIDTH-1:0] r_data [NUM_SLOTS];
  logic [RESP_WIDTH-1:0] r_resp [NUM_SLOTS];
  logic                  r_last [NUM_SLOTS];
  logic [SW-1:0]         r_next [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  r_free;

  logic [SW-1:0] r_head  [NUM_UIDS];
  logic [SW-1:0] r_tail  [NUM_UIDS];
  logic [CW-1:0] r_count [NUM_UIDS];

  logic [SW-1:0] w_alloc;
  logic [SW-1:0] w_rel_head;
  logic          w_store;
  logic          w_release;
  logic          w_same_uid;

  // Lowest-index free slot wins.
  always_comb begin
    w_alloc = '0;
    for (int i = NUM_SLOTS-1; i >= 0; i--) begin
      if (r_free[i]) w_alloc = SW'(i);
    end
  end

  assign store_ready   = (|r_free) && (r_count[store_id] < CW'(MAX_LEN));
  assign release_valid = (r_count[release_uid] != '0);
  assign w_rel_head    = r_head[release_uid];
  assign release_data  = release_valid ? r_data[w_rel_head] : '0;
  assign release_resp  = release_valid ? r_resp[w_rel_head] : '0;
  assign release_last  = release_valid ? r_last[w_rel_head] : 1'b0;

  assign w_store    = store_valid && store_ready;
  assign w_release  = release_valid && release_ready;
  assign w_same_uid = (store_id == release_uid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_free <= '1;
      for (int u = 0; u < NUM_UIDS; u++) begin
        r_head[u]  <= '0;
        r_tail[u]  <= '0;
        r_count[u] <= '0;
      end
    end else begin
      if (w_store) begin
        r_free[w_alloc]  <= 1'b0;
        r_tail[store_id] <= w_alloc;
        if (r_count[store_id] == '0) r_head[store_id] <= w_alloc;
      end
      if (w_release) begin
        r_free[w_rel_head] <= 1'b1;
        // A single-beat chain popped while the same uid stores: new beat becomes the head.
        if (w_store && w_same_uid && r_count[release_uid] == CW'(1))
          r_head[release_uid] <= w_alloc;
        else
          r_head[release_uid] <= r_next[w_rel_head];
      end
      if (!(w_store && w_release && w_same_uid)) begin
        if (w_store)   r_count[store_id]    <= r_count[store_id] + CW'(1);
        if (w_release) r_count[release_uid] <= r_count[release_uid] - CW'(1);
      end
    end
  end

  // Slot payload needs no reset; it is only visible through a live chain.
  always_ff @(posedge clk) begin
    if (!rst && w_store) begin
      r_data[w_alloc] <= store_data;
      r_resp[w_alloc] <= store_resp;
      r_last[w_alloc] <= store_last;
      if (r_count[store_id] != '0) r_next[r_tail[store_id]] <= w_alloc;
    end
  end

`ifdef RM_STATS_EN
  localparam int OW = $clog2(NUM_SLOTS+1);
  logic [OW-1:0] r_occ;
  logic [OW-1:0] r_peak;
  logic [OW-1:0] w_occ_next;

  always_comb begin
    w_occ_next = r_occ;
    if (w_store && !w_release)      w_occ_next = r_occ + OW'(1);
    else if (!w_store && w_release) w_occ_next = r_occ - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ  <= '0;
      r_peak <= '0;
    end else begin
      r_occ <= w_occ_next;
      if (w_occ_next > r_peak) r_peak <= w_occ_next;
    end
  end

  assign occupancy      = r_occ;
  assign peak_occupancy = r_peak;
`endif

endmodule

// File: tb/tb_r_response_memory.sv
// Bench for r_response_memory: directed scenarios plus randomized traffic against a per-uid queue model.
module tb_r_response_memory;

  localparam int IW = 4;
  localparam int DW = 32;
  localparam int RW = 2;
  localparam int NS = 32;
  localparam int ML = 8;
  localparam int NU = 16;

  typedef logic [DW+RW:0] beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          store_valid;
  logic          store_ready;
  logic [IW-1:0] store_id;
  logic [DW-1:0] store_data;
  logic [RW-1:0] store_resp;
  logic          store_last;
  logic [IW-1:0] release_uid;
  logic          release_ready;
  logic          release_valid;
  logic [DW-1:0] release_data;
  logic [RW-1:0] release_resp;
  logic          release_last;
`ifdef RM_STATS_EN
  logic [5:0]    occupancy;
  logic [5:0]    peak_occupancy;
`endif

  r_response_memory dut (
    .clk           (clk),
    .rst           (rst),
    .store_valid   (store_valid),
    .store_ready   (store_ready),
    .store_id      (store_id),
    .store_data    (store_data),
    .store_resp    (store_resp),
    .store_last    (store_last),
    .release_uid   (release_uid),
    .release_ready (release_ready),
    .release_valid (release_valid),
    .release_data  (release_data),
    .release_resp  (release_resp),
    .release_last  (release_last)
`ifdef RM_STATS_EN
    ,
    .occupancy      (occupancy),
    .peak_occupancy (peak_occupancy)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one FIFO per uid plus a pool-wide beat count.
  beat_t mq [NU][$];
  int    m_total = 0;
  int    m_peak  = 0;

  function automatic bit m_sr(int id);
    return (m_total < NS) && (mq[id].size() < ML);
  endfunction

  function automatic bit m_rv(int u);
    return mq[u].size() != 0;
  endfunction

  function automatic beat_t m_head(int u);
    if (mq[u].size() == 0) return '0;
    return mq[u][0];
  endfunction

  task automatic drive(bit sv, int sid, logic [DW-1:0] sd, bit sl, int ru, bit rr);
    store_valid   = sv;
    store_id      = IW'(sid);
    store_data    = sd;
    store_resp    = RW'($urandom_range(0, 3));
    store_last    = sl;
    release_uid   = IW'(ru);
    release_ready = rr;
  endtask

  // Advances one clock and applies the handshakes the model predicts for the current inputs.
  task automatic tick();
    bit    st, rl;
    int    sid, ru;
    beat_t b;
    st  = store_valid && m_sr(int'(store_id));
    rl  = release_ready && m_rv(int'(release_uid));
    sid = int'(store_id);
    ru  = int'(release_uid);
    b   = {store_last, store_resp, store_data};
    @(posedge clk);
    if (rst) begin
      for (int u = 0; u < NU; u++) mq[u].delete();
      m_total = 0;
      m_peak  = 0;
    end else begin
      if (rl) begin
        void'(mq[ru].pop_front());
        m_total--;
      end
      if (st) begin
        mq[sid].push_back(b);
        m_total++;
      end
      if (m_total > m_peak) m_peak = m_total;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, '0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, '0, 0, 0, 0);
    #2;
    n_tests++;
    if (store_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_store_ready got=%b exp=1", store_ready);
    end
    n_tests++;
    if ({release_valid, release_last, release_resp, release_data} !== '0) begin
      n_fail++; $display("FAIL reset_release got v=%b d=%h exp all 0", release_valid, release_data);
    end
`ifdef RM_STATS_EN
    n_tests++;
    if (occupancy !== 6'd0 || peak_occupancy !== 6'd0) begin
      n_fail++; $display("FAIL reset_stats got occ=%0d peak=%0d exp 0", occupancy, peak_occupancy);
    end
`endif
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    drive(1, 5, 32'hA0, 0, 5, 0);
    #2;
    n_tests++;
    if (release_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_empty got valid=%b exp=0", release_valid);
    end
    tick();
    drive(1, 5, 32'hA1, 1, 5, 0);
    #2;
    n_tests++;
    if (release_valid !== 1'b1 || release_data !== 32'hA0) begin
      n_fail++; $display("FAIL basic_first got v=%b d=%h exp v=1 d=a0", release_valid, release_data);
    end
    tick();
    drive(0, 5, '0, 0, 5, 1);
    #2;
    n_tests++;
    if (release_data !== 32'hA0 || release_last !== 1'b0) begin
      n_fail++; $display("FAIL basic_pop0 got d=%h l=%b exp d=a0 l=0", release_data, release_last);
    end
    tick();
    #2;
    n_tests++;
    if (release_valid !== 1'b1 || release_data !== 32'hA1 || release_last !== 1'b1) begin
      n_fail++; $display("FAIL basic_pop1 got v=%b d=%h l=%b exp v=1 d=a1 l=1", release_valid, release_data, release_last);
    end
    tick();
    drive(0, 5, '0, 0, 5, 0);
    #2;
    n_tests++;
    if (release_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_drained got valid=%b exp=0", release_valid);
    end
    tick();
  endtask

  task automatic test_interleave();
    logic [DW-1:0] exp_d [3];
    do_reset();
    drive(1, 3, 32'h30, 0, 0, 0); tick();
    drive(1, 7, 32'h70, 1, 0, 0); tick();
    drive(1, 3, 32'h31, 1, 0, 0); tick();
    drive(0, 0, '0, 0, 7, 1);
    #2;
    n_tests++;
    if (release_valid !== 1'b1 || release_data !== 32'h70) begin
      n_fail++; $display("FAIL interleave_uid7 got v=%b d=%h exp d=70", release_valid, release_data);
    end
    tick();
    exp_d[0] = 32'h30; exp_d[1] = 32'h31; exp_d[2] = 32'h32;
    // Reuse uid7's freed slot for uid3 while uid3's chain is being popped.
    drive(1, 3, 32'h32, 1, 3, 1);
    for (int k = 0; k < 3; k++) begin
      #2;
      n_tests++;
      if (release_valid !== 1'b1 || release_data !== exp_d[k]) begin
        n_fail++; $display("FAIL interleave_uid3_%0d got v=%b d=%h exp d=%h", k, release_valid, release_data, exp_d[k]);
      end
      tick();
      drive(0, 3, '0, 0, 3, 1);
    end
    #2;
    n_tests++;
    if (release_valid !== 1'b0) begin
      n_fail++; $display("FAIL interleave_drained got valid=%b exp=0", release_valid);
    end
    drive(0, 0, '0, 0, 0, 0);
    tick();
  endtask

  task automatic test_uid_full();
    do_reset();
    for (int k = 0; k < ML; k++) begin
      drive(1, 2, DW'(k), k == ML-1, 0, 0);
      tick();
    end
    drive(0, 2, '0, 0, 2, 0);
    #2;
    n_tests++;
    if (store_ready !== 1'b0) begin
      n_fail++; $display("FAIL uidfull_uid2 got ready=%b exp=0", store_ready);
    end
    store_id = 4'd4;
    #1;
    n_tests++;
    if (store_ready !== 1'b1) begin
      n_fail++; $display("FAIL uidfull_uid4 got ready=%b exp=1", store_ready);
    end
    drive(0, 2, '0, 0, 2, 1);
    tick();
    drive(0, 2, '0, 0, 2, 0);
    #2;
    n_tests++;
    if (store_ready !== 1'b1 || release_data !== 32'd1) begin
      n_fail++; $display("FAIL uidfull_after_pop got ready=%b d=%h exp ready=1 d=1", store_ready, release_data);
    end
    tick();
  endtask

  task automatic test_pool_full();
    do_reset();
    for (int u = 0; u < 4; u++) begin
      for (int k = 0; k < ML; k++) begin
        drive(1, u, DW'(u*256 + k), 0, 0, 0);
        tick();
      end
    end
    drive(1, 4, 32'hBEEF, 1, 0, 1);
    #2;
    n_tests++;
    if (store_ready !== 1'b0 || release_valid !== 1'b1 || release_data !== 32'h0) begin
      n_fail++; $display("FAIL poolfull_same_cycle got ready=%b v=%b d=%h exp ready=0 v=1 d=0", store_ready, release_valid, release_data);
    end
    tick();
    drive(1, 4, 32'hBEEF, 1, 0, 0);
    #2;
    n_tests++;
    if (store_ready !== 1'b1 || release_data !== 32'h1) begin
      n_fail++; $display("FAIL poolfull_next_cycle got ready=%b d=%h exp ready=1 d=1", store_ready, release_data);
    end
    tick();
    drive(0, 4, '0, 0, 4, 0);
    #2;
    n_tests++;
    if (release_valid !== 1'b1 || release_data !== 32'hBEEF || release_last !== 1'b1 || store_ready !== 1'b0) begin
      n_fail++; $display("FAIL poolfull_new_beat got v=%b d=%h l=%b ready=%b exp v=1 d=beef l=1 ready=0", release_valid, release_data, release_last, store_ready);
    end
    tick();
  endtask

  task automatic test_same_uid();
    do_reset();
    drive(1, 9, 32'h90, 0, 0, 0); tick();
    drive(1, 9, 32'h91, 1, 9, 1);
    #2;
    n_tests++;
    if (release_data !== 32'h90 || store_ready !== 1'b1) begin
      n_fail++; $display("FAIL sameuid_pop_store got d=%h ready=%b exp d=90 ready=1", release_data, store_ready);
    end
    tick();
    drive(0, 9, '0, 0, 9, 1);
    #2;
    n_tests++;
    if (release_valid !== 1'b1 || release_data !== 32'h91) begin
      n_fail++; $display("FAIL sameuid_next got v=%b d=%h exp v=1 d=91", release_valid, release_data);
    end
    tick();
    drive(1, 6, 32'h60, 0, 6, 1);
    #2;
    n_tests++;
    if (release_valid !== 1'b0) begin
      n_fail++; $display("FAIL sameuid_count1 got valid=%b exp=0 (uid 9 or 6)", release_valid);
    end
    tick();
    drive(0, 6, '0, 0, 6, 0);
    #2;
    n_tests++;
    if (release_valid !== 1'b1 || release_data !== 32'h60) begin
      n_fail++; $display("FAIL sameuid_nobypass got v=%b d=%h exp v=1 d=60", release_valid, release_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1, $urandom_range(0, 15), $urandom, 0, 0, 0);
      tick();
    end
    rst = 1'b1;
    drive(1, 1, 32'h55, 0, 0, 1);
    tick();
    rst = 1'b0;
    drive(0, 0, '0, 0, 0, 0);
    bad = 0;
    for (int u = 0; u < NU; u++) begin
      release_uid = IW'(u);
      store_id    = IW'(u);
      #1;
      if (release_valid !== 1'b0 || release_data !== '0 || store_ready !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL reset_mid got %0d uids not cleared exp 0", bad);
    end
`ifdef RM_STATS_EN
    n_tests++;
    if (occupancy !== 6'd0 || peak_occupancy !== 6'd0) begin
      n_fail++; $display("FAIL reset_mid_stats got occ=%0d peak=%0d exp 0", occupancy, peak_occupancy);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    beat_t exp_b;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 4), $urandom, $urandom_range(0, 1),
            $urandom_range(0, 4), $urandom_range(0, 9) < 5);
      #2;
      exp_b = m_head(int'(release_uid));
      n_tests++;
      if (store_ready !== m_sr(int'(store_id))) begin
        n_fail++; $display("FAIL rand_store_ready c=%0d id=%0d got=%b exp=%b", c, store_id, store_ready, m_sr(int'(store_id)));
      end
      n_tests++;
      if (release_valid !== m_rv(int'(release_uid)) || {release_last, release_resp, release_data} !== exp_b) begin
        n_fail++; $display("FAIL rand_release c=%0d uid=%0d got v=%b beat=%h exp v=%b beat=%h", c, release_uid,
                           release_valid, {release_last, release_resp, release_data}, m_rv(int'(release_uid)), exp_b);
      end
`ifdef RM_STATS_EN
      n_tests++;
      if (int'(occupancy) != m_total || int'(peak_occupancy) != m_peak) begin
        n_fail++; $display("FAIL rand_stats c=%0d got occ=%0d peak=%0d exp occ=%0d peak=%0d", c, occupancy, peak_occupancy, m_total, m_peak);
      end
`endif
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, '0, 0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_interleave();
    test_uid_full();
    test_pool_full();
    test_same_uid();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
